// File: rtl/frame_phase_scheduler_if.sv
// rtl/frame_phase_scheduler_if.sv - frame tick, phase handshake and status bundle for frame_phase_scheduler
interface frame_phase_scheduler_if #(
  parameter int N_PHASES = 4,
  parameter int PH_W     = 2,
  parameter int FCNT_W   = 16
);
  logic                frame_tick;
  logic                pause;
  logic                clr_err;
  logic [N_PHASES-1:0] phase_done;
  logic [N_PHASES-1:0] phase_start;
  logic [N_PHASES-1:0] phase_active;
  logic [PH_W-1:0]     cur_phase;
  logic                busy;
  logic [FCNT_W-1:0]   frame_count;
  logic                overrun;
  logic                timeout_err;

  // Driver side: frame-tick generator plus the game-logic phase blocks.
  modport master (
    output frame_tick, pause, clr_err, phase_done,
    input  phase_start, phase_active, cur_phase, busy, frame_count, overrun, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  frame_tick, pause, clr_err, phase_done,
    output phase_start, phase_active, cur_phase, busy, frame_count, overrun, timeout_err
  );
endinterface

// File: rtl/frame_phase_scheduler.sv
// rtl/frame_phase_scheduler.sv - sequences per-frame update phases with overrun and watchdog flags
module frame_phase_scheduler #(
  parameter int              N_PHASES   = 4,
  parameter int              PH_W       = 2,
  parameter int              WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = {WDOG_W{1'b1}},
  parameter int              FCNT_W     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  frame_phase_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PH_W-1:0]     LAST_IDX = PH_W'(N_PHASES - 1);
  localparam logic [N_PHASES-1:0] ONE_HOT0 = {{(N_PHASES-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [PH_W-1:0]     r_idx;
  logic [WDOG_W-1:0]   r_wdog;
  logic [FCNT_W-1:0]   r_fcnt;
  logic                r_overrun;
  logic                r_timeout;

  state_t              w_state_nxt;
  logic [PH_W-1:0]     w_idx_nxt;
  logic [WDOG_W-1:0]   w_wdog_nxt;
  logic [FCNT_W-1:0]   w_fcnt_nxt;
  logic                w_advance;
  logic                w_to_set;
  logic                w_ovr_set;
  logic [N_PHASES-1:0] w_onehot;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wdog    <= '0;
      r_fcnt    <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wdog    <= w_wdog_nxt;
      r_fcnt    <= w_fcnt_nxt;
      // Setting a flag takes priority over a simultaneous clear.
      r_overrun <= w_ovr_set | (r_overrun & ~bus.clr_err);
      r_timeout <= w_to_set  | (r_timeout & ~bus.clr_err);
    end
  end

  // Next-state logic: tick starts a frame, each phase is START then WAIT, DONE bumps the count.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wdog_nxt  = r_wdog;
    w_fcnt_nxt  = r_fcnt;
    w_advance   = 1'b0;
    w_to_set    = 1'b0;
    w_ovr_set   = bus.frame_tick && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.frame_tick && !bus.pause) begin
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_wdog_nxt = r_wdog + 1'b1;
        // Only the current phase's done bit counts; a hung phase is skipped as if done.
        if (bus.phase_done[r_idx]) begin
          w_advance = 1'b1;
        end else if (r_wdog == WDOG_LIMIT) begin
          w_to_set  = 1'b1;
          w_advance = 1'b1;
        end
        if (w_advance) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_START;
          end
        end
      end
      S_DONE: begin
        w_fcnt_nxt  = r_fcnt + 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_onehot = ONE_HOT0 << r_idx;

  // Outputs decode from registers only, so no input reaches an output combinationally.
  assign bus.phase_start  = (r_state == S_START) ? w_onehot : '0;
  assign bus.phase_active = (r_state == S_START || r_state == S_WAIT) ? w_onehot : '0;
  assign bus.cur_phase    = r_idx;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.frame_count  = r_fcnt;
  assign bus.overrun      = r_overrun;
  assign bus.timeout_err  = r_timeout;

endmodule

// File: tb/tb_frame_phase_scheduler.sv
// tb/tb_frame_phase_scheduler.sv - self-checking bench for frame_phase_scheduler
module tb_frame_phase_scheduler;
  localparam int N      = 4;
  localparam int PH_W   = 2;
  localparam int WDOG_W = 4;
  localparam int LIM    = 8;
  localparam int FCNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (frame-level)
  int exp_cnt = 0;
  bit exp_ovr = 0;
  bit exp_to  = 0;

  // Frame scenario knobs
  int dly [N];
  bit noisy      = 0;
  bit junk       = 0;
  bit hold_pause = 0;
  int tick_at    = -1;
  int clr_at     = -1;

  frame_phase_scheduler_if #(.N_PHASES(N), .PH_W(PH_W), .FCNT_W(FCNT_W)) bus ();

  frame_phase_scheduler #(
    .N_PHASES(N), .PH_W(PH_W), .WDOG_W(WDOG_W),
    .WDOG_LIMIT(WDOG_W'(LIM)), .FCNT_W(FCNT_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    exp_ovr = 0;
    exp_to  = 0;
  endtask

  // One frame: phase k's done arrives dly[k] cycles after its start (0 = never, watchdog fires).
  // The expected timeline is built from start offsets s[k] computed arithmetically.
  task automatic run_frame();
    int s [N+1];
    int k, total;
    bit bsy, tk, cl;
    logic [N-1:0]    e_start, e_act, done_v;
    logic [PH_W-1:0] e_cur;
    s[0] = 1;
    for (int p = 0; p < N; p++) s[p+1] = s[p] + ((dly[p] == 0) ? LIM + 1 : dly[p]) + 1;
    total = s[N] + 1;
    for (int r = 0; r <= total; r++) begin
      e_start = '0; e_act = '0; e_cur = '0; k = -1;
      bsy = (r > 0) && (r < total);
      for (int p = 0; p < N; p++) if (r >= s[p] && r < s[p+1]) k = p;
      if (k >= 0) begin
        e_act = N'(1) << k;
        e_cur = PH_W'(k);
        if (r == s[k]) e_start = N'(1) << k;
      end else if (r == s[N]) begin
        e_cur = PH_W'(N - 1);
      end
      n_cmp += 7;
      if (bus.phase_start !== e_start) begin n_bad++; $display("FAIL frame.phase_start r=%0d got %b exp %b", r, bus.phase_start, e_start); end
      if (bus.phase_active !== e_act) begin n_bad++; $display("FAIL frame.phase_active r=%0d got %b exp %b", r, bus.phase_active, e_act); end
      if (bus.cur_phase !== e_cur) begin n_bad++; $display("FAIL frame.cur_phase r=%0d got %0d exp %0d", r, bus.cur_phase, e_cur); end
      if (bus.busy !== bsy) begin n_bad++; $display("FAIL frame.busy r=%0d got %b exp %b", r, bus.busy, bsy); end
      if (bus.frame_count !== FCNT_W'(exp_cnt)) begin n_bad++; $display("FAIL frame.count r=%0d got %0d exp %0d", r, bus.frame_count, exp_cnt); end
      if (bus.overrun !== exp_ovr) begin n_bad++; $display("FAIL frame.overrun r=%0d got %b exp %b", r, bus.overrun, exp_ovr); end
      if (bus.timeout_err !== exp_to) begin n_bad++; $display("FAIL frame.timeout r=%0d got %b exp %b", r, bus.timeout_err, exp_to); end
      if (r < total) begin
        tk = (r == 0) || (r == tick_at) || (noisy && bsy && $urandom_range(0, 9) == 0);
        cl = (r == clr_at) || (noisy && $urandom_range(0, 7) == 0);
        done_v = noisy ? N'($urandom) : (junk ? '1 : '0);
        if (k >= 0 && r != s[k]) done_v[k] = (dly[k] != 0) && (r == s[k] + dly[k]);
        bus.frame_tick = tk;
        bus.clr_err    = cl;
        bus.phase_done = done_v;
        bus.pause      = (r == 0) ? 1'b0 : (hold_pause || (noisy && $urandom_range(0, 1) == 1));
        if (tk && bsy) exp_ovr = 1; else if (cl) exp_ovr = 0;
        if (k >= 0 && dly[k] == 0 && r == s[k+1] - 1) exp_to = 1; else if (cl) exp_to = 0;
        if (r == s[N]) exp_cnt = (exp_cnt + 1) % (1 << FCNT_W);
        step();
      end else begin
        bus.frame_tick = 1'b0; bus.clr_err = 1'b0; bus.phase_done = '0; bus.pause = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({bus.phase_start, bus.phase_active, bus.cur_phase, bus.busy, bus.frame_count, bus.overrun, bus.timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset.outputs got %b exp 0", {bus.phase_start, bus.phase_active, bus.cur_phase, bus.busy, bus.frame_count, bus.overrun, bus.timeout_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    int c0 = exp_cnt;
    logic [N-1:0] es;
    for (int r = 0; r <= 10; r++) begin
      es = (r == 1) ? 4'b0001 : (r == 3) ? 4'b0010 : (r == 5) ? 4'b0100 : (r == 7) ? 4'b1000 : 4'b0000;
      n_cmp += 3;
      if (bus.phase_start !== es) begin n_bad++; $display("FAIL latency.start r=%0d got %b exp %b", r, bus.phase_start, es); end
      if (bus.busy !== (r >= 1 && r <= 9)) begin n_bad++; $display("FAIL latency.busy r=%0d got %b", r, bus.busy); end
      if (bus.frame_count !== FCNT_W'((r == 10) ? c0 + 1 : c0)) begin
        n_bad++; $display("FAIL latency.count r=%0d got %0d base %0d", r, bus.frame_count, c0);
      end
      if (r < 10) begin
        bus.frame_tick = (r == 0);
        bus.phase_done = (r == 2) ? 4'b0001 : (r == 4) ? 4'b0010 : (r == 6) ? 4'b0100 : (r == 8) ? 4'b1000 : 4'b0000;
        step();
      end
    end
    bus.frame_tick = 1'b0;
    bus.phase_done = '0;
    exp_cnt = (c0 + 1) % (1 << FCNT_W);
  endtask

  task automatic test_pause();
    bus.pause = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    for (int r = 0; r < 4; r++) begin
      n_cmp += 4;
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL pause.busy r=%0d got %b exp 0", r, bus.busy); end
      if (bus.phase_start !== '0) begin n_bad++; $display("FAIL pause.start r=%0d got %b exp 0", r, bus.phase_start); end
      if (bus.frame_count !== FCNT_W'(exp_cnt)) begin n_bad++; $display("FAIL pause.count got %0d exp %0d", bus.frame_count, exp_cnt); end
      if (bus.overrun !== exp_ovr) begin n_bad++; $display("FAIL pause.overrun got %b exp %b", bus.overrun, exp_ovr); end
      step();
    end
    dly = '{1, 2, 1, 3};
    hold_pause = 1;
    run_frame();
    hold_pause = 0;
    n_cmp++;
    if (bus.frame_count !== FCNT_W'(exp_cnt)) begin n_bad++; $display("FAIL pause.midframe_count got %0d exp %0d", bus.frame_count, exp_cnt); end
  endtask

  task automatic test_overrun();
    clr_pulse();
    dly = '{1, 1, 1, 1};
    tick_at = 3;
    run_frame();
    n_cmp++;
    if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.set got %b exp 1", bus.overrun); end
    tick_at = -1;
    clr_pulse();
    n_cmp++;
    if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL overrun.clear got %b exp 0", bus.overrun); end
    tick_at = 4;
    clr_at  = 4;
    run_frame();
    n_cmp++;
    if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.set_wins got %b exp 1", bus.overrun); end
    tick_at = -1;
    clr_at  = -1;
  endtask

  task automatic test_timeout();
    clr_pulse();
    dly = '{0, 2, 1, 1};
    junk = 1;
    run_frame();
    junk = 0;
    n_cmp++;
    if (bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout.flag got %b exp 1", bus.timeout_err); end
  endtask

  task automatic test_random();
    int v;
    noisy = 1;
    for (int f = 0; f < 30; f++) begin
      for (int p = 0; p < N; p++) begin
        v = $urandom_range(0, 9);
        dly[p] = (v == 0) ? 0 : (v % 4) + 1;
      end
      run_frame();
    end
    noisy = 0;
  endtask

  task automatic test_wrap();
    clr_pulse();
    for (int g = 0; g < 20 && exp_cnt != 15; g++) begin
      for (int p = 0; p < N; p++) dly[p] = $urandom_range(1, 3);
      run_frame();
    end
    n_cmp++;
    if (bus.frame_count !== 4'd15) begin n_bad++; $display("FAIL wrap.pre got %0d exp 15", bus.frame_count); end
    dly = '{2, 1, 3, 1};
    run_frame();
    n_cmp += 2;
    if (bus.frame_count !== 4'd0) begin n_bad++; $display("FAIL wrap.post got %0d exp 0", bus.frame_count); end
    if ({bus.overrun, bus.timeout_err} !== 2'b00) begin n_bad++; $display("FAIL wrap.flags got %b exp 00", {bus.overrun, bus.timeout_err}); end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 6; r++) begin
      bus.frame_tick = (r == 0) || (r == 3);
      bus.phase_done = (r == 2) ? 4'b0001 : (r == 4) ? 4'b0010 : 4'b0000;
      step();
    end
    bus.frame_tick = 1'b0;
    bus.phase_done = '0;
    n_cmp++;
    if ({bus.phase_active, bus.overrun} !== 5'b0100_1) begin n_bad++; $display("FAIL rstmid.setup got %b exp 01001", {bus.phase_active, bus.overrun}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.phase_start, bus.phase_active, bus.cur_phase, bus.busy, bus.frame_count, bus.overrun, bus.timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL rstmid.outputs got %b exp 0", {bus.phase_start, bus.phase_active, bus.cur_phase, bus.busy, bus.frame_count, bus.overrun, bus.timeout_err});
    end
    exp_cnt = 0; exp_ovr = 0; exp_to = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    n_cmp++;
    if (bus.phase_start !== 4'b0001) begin n_bad++; $display("FAIL rstmid.restart got %b exp 0001", bus.phase_start); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.pause      = 1'b0;
    bus.clr_err    = 1'b0;
    bus.phase_done = '0;
    test_reset();
    test_latency();
    test_pause();
    test_overrun();
    test_timeout();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
